seq_multiplier_n: RTL and testbench

- Parametrised sequential shift-add multiplier with its control FSM and datapath in one block.
- Successor to the fixed 4-bit multiplier control.
- New capabilities over that block: any operand WIDTH, optional two's-complement mode, early termination once the remaining multiplier bits are zero, and a start/busy/done handshake with a held product register.
- Sits between a requesting unit and the result consumer, one multiply in flight at a time.

---
 rtl/seq_multiplier_n.sv | 119 +++++++++++
 tb/tb_seq_multiplier_n.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/seq_multiplier_n.sv
// Parametrised shift-add multiplier: IDLE/CALC/DONE control and datapath in one block.
// Signed operands are multiplied as magnitudes and the sign is applied when the product is written.
module seq_multiplier_n #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [PW-1:0]   md_r;
  logic [WIDTH-1:0] mr_r;
  logic [PW-1:0]   acc_r;
  logic [CW-1:0]   cnt_r;
  logic            neg_r;
  logic [PW-1:0]   product_r;

  logic            finish_s;
  logic [PW-1:0]   acc_next_s;
  logic [PW-1:0]   product_next_s;

  // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is exactly right when read as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      magnitude = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      magnitude = v;
    end
  endfunction

  // Termination test, conditional accumulate and signed result for the current CALC step.
  always_comb begin
    finish_s       = 1'b0;
    acc_next_s     = acc_r;
    product_next_s = acc_r;
    if ((cnt_r == CW'(WIDTH)) || (EARLY_TERM && (mr_r == {WIDTH{1'b0}}))) begin
      finish_s = 1'b1;
    end else begin
      finish_s = 1'b0;
    end
    if (mr_r[0]) begin
      acc_next_s = acc_r + md_r;
    end else begin
      acc_next_s = acc_r;
    end
    if (neg_r) begin
      product_next_s = ~acc_r + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      product_next_s = acc_r;
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      md_r      <= {PW{1'b0}};
      mr_r      <= {WIDTH{1'b0}};
      acc_r     <= {PW{1'b0}};
      cnt_r     <= {CW{1'b0}};
      neg_r     <= 1'b0;
      product_r <= {PW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            md_r    <= {{WIDTH{1'b0}}, magnitude(multiplicand, signed_mode)};
            mr_r    <= magnitude(multiplier, signed_mode);
            neg_r   <= signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
            acc_r   <= {PW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            state_r <= ST_CALC;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CALC: begin
          if (finish_s) begin
            product_r <= product_next_s;
            state_r   <= ST_DONE;
          end else begin
            acc_r <= acc_next_s;
            md_r  <= {md_r[PW-2:0], 1'b0};
            mr_r  <= {1'b0, mr_r[WIDTH-1:1]};
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = (state_r == ST_CALC);
  assign done    = (state_r == ST_DONE);
  assign product = product_r;

endmodule

// File: tb/tb_seq_multiplier_n.sv
// Directed bench for seq_multiplier_n: one instance per EARLY_TERM setting, driven in lock-step.
module tb_seq_multiplier_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [7:0]  multiplicand = 8'h00;
  logic [7:0]  multiplier = 8'h00;
  logic        busy_f, done_f, busy_e, done_e;
  logic [15:0] product_f, product_e;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    int          lat_e;
  } vec_t;

  vec_t vecs [10];

  seq_multiplier_n #(.WIDTH(8), .EARLY_TERM(1'b0)) dut_full (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy_f), .done(done_f), .product(product_f)
  );

  seq_multiplier_n #(.WIDTH(8), .EARLY_TERM(1'b1)) dut_early (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy_e), .done(done_e), .product(product_e)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one multiply and observe both instances for a fixed window covering the longest latency.
  task automatic run_vec(input string tag, input logic sm, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] ep, input int le);
    int lat_f = 0, lat_e = 0, bsy_f = 0, bsy_e = 0, dn_f = 0, dn_e = 0;
    start = 1'b1; signed_mode = sm; multiplicand = a; multiplier = b;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        start = 1'b0; multiplicand = 8'hA5; multiplier = 8'h5A;
      end
      if (busy_f) bsy_f++;
      if (busy_e) bsy_e++;
      if (done_f) begin dn_f++; if (lat_f == 0) lat_f = i; end
      if (done_e) begin dn_e++; if (lat_e == 0) lat_e = i; end
    end
    chk({tag, ".prod_full"},  {16'h0000, product_f}, {16'h0000, ep});
    chk({tag, ".prod_early"}, {16'h0000, product_e}, {16'h0000, ep});
    chk({tag, ".lat_full"},   lat_f, 9);
    chk({tag, ".lat_early"},  lat_e, le);
    chk({tag, ".busy_full"},  bsy_f, 9);
    chk({tag, ".busy_early"}, bsy_e, le);
    chk({tag, ".donew_full"}, dn_f, 1);
    chk({tag, ".donew_early"}, dn_e, 1);
  endtask

  initial begin
    logic [15:0] q_f [$];
    logic [15:0] q_e [$];
    logic [15:0] exp_e [4];
    logic [15:0] held_f, held_e;
    int glitch = 0;

    //            signed  A      B      product  early latency
    vecs[0] = '{1'b0, 8'd13, 8'd11, 16'h008F, 5};
    vecs[1] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 9};
    vecs[2] = '{1'b0, 8'd13, 8'h00, 16'h0000, 1};
    vecs[3] = '{1'b0, 8'd3,  8'h80, 16'h0180, 9};
    vecs[4] = '{1'b1, 8'hF9, 8'h05, 16'hFFDD, 4};
    vecs[5] = '{1'b1, 8'h80, 8'h80, 16'h4000, 9};
    vecs[6] = '{1'b1, 8'h7F, 8'hFF, 16'hFF81, 2};
    vecs[7] = '{1'b0, 8'hF9, 8'h05, 16'h04DD, 4};
    vecs[8] = '{1'b1, 8'h00, 8'hFF, 16'h0000, 2};
    vecs[9] = '{1'b1, 8'h05, 8'h00, 16'h0000, 1};

    // Reset and idle
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst.busy",  {30'd0, busy_f, busy_e}, 32'd0);
    chk("rst.done",  {30'd0, done_f, done_e}, 32'd0);
    chk("rst.prod",  {product_f, product_e}, 32'd0);
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("idle.busy", {30'd0, busy_f, busy_e}, 32'd0);
    chk("idle.prod", {product_f, product_e}, 32'd0);

    for (int v = 0; v < 10; v++) begin
      run_vec($sformatf("vec%0d", v), vecs[v].sm, vecs[v].a, vecs[v].b, vecs[v].p, vecs[v].lat_e);
    end

    // start held high with operands changing every cycle; only IDLE-sampled operands count
    held_f = vecs[9].p; held_e = vecs[9].p;
    signed_mode = 1'b0;
    for (int j = 0; j < 22; j++) begin
      start = 1'b1; multiplicand = 8'(j + 2); multiplier = 8'd3;
      @(posedge clk); #1;
      if (done_f) begin q_f.push_back(product_f); held_f = product_f; end
      else if (product_f !== held_f) glitch++;
      if (done_e) begin q_e.push_back(product_e); held_e = product_e; end
      else if (product_e !== held_e) glitch++;
    end
    start = 1'b0;
    exp_e = '{16'd6, 16'd21, 16'd36, 16'd51};
    chk("held.ndone_full",  q_f.size(), 2);
    chk("held.ndone_early", q_e.size(), 4);
    if (q_f.size() == 2) begin
      chk("held.full0", {16'h0000, q_f[0]}, 32'd6);
      chk("held.full1", {16'h0000, q_f[1]}, 32'd39);
    end
    if (q_e.size() == 4) begin
      for (int k = 0; k < 4; k++) chk($sformatf("held.early%0d", k), {16'h0000, q_e[k]}, {16'h0000, exp_e[k]});
    end
    repeat (12) begin @(posedge clk); #1; end
    chk("held.glitch",     glitch, 0);
    chk("held.final_full",  {16'h0000, product_f}, 32'd39);
    chk("held.final_early", {16'h0000, product_e}, 32'd66);

    // Reset in the third CALC cycle of 255*255
    start = 1'b1; signed_mode = 1'b0; multiplicand = 8'hFF; multiplier = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst.busy", {30'd0, busy_f, busy_e}, 32'd0);
    chk("midrst.done", {30'd0, done_f, done_e}, 32'd0);
    chk("midrst.prod", {product_f, product_e}, 32'd0);
    rst = 1'b0;
    run_vec("after_rst", 1'b0, 8'd3, 8'd4, 16'h000C, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
